sar_search: RTL and testbench

- Successive-approximation search controller: the driving side of the bitComparator interface.
- It finds an unknown operand `a` that sits on the comparator's `a` input.
- It drives the comparator's `b` and `sig` inputs and consumes its `lg`/`eq`/`ls` flags, one probe per clock.
- Used for threshold/value recovery wherever only a magnitude comparator can observe a quantity.

---
 rtl/sar_search_pkg.sv | 15 +
 rtl/sar_search.sv | 129 ++++++++++++
 tb/tb_sar_search.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search controller.
package sar_search_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StProbe = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Sign mask that turns an offset-binary trial into a two's-complement probe.
  function automatic logic [31:0] sign_mask(input logic sig, input int unsigned width);
    return sig ? (32'd1 << (width - 1)) : 32'd0;
  endfunction

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search controller driving a magnitude comparator.
// The trial register is offset-binary, so a signed search is just an unsigned
// binary search with the MSB flipped on the way out to the comparator.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STEP_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              sig_in_i,
  output logic [WIDTH-1:0]  b_o,
  output logic              sig_o,
  input  logic              lg_i,
  input  logic              eq_i,
  input  logic              ls_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [WIDTH-1:0]  result_o,
  output logic [STEP_W-1:0] steps_o,
  output logic              err_o
);

  state_e              state_q, state_d;
  logic                sig_q, sig_d;
  logic [WIDTH-1:0]    trial_q, trial_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [STEP_W-1:0]   idx_q, idx_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic                err_q, err_d;

  logic [WIDTH-1:0]    mask;
  logic [WIDTH-1:0]    probe;
  logic [WIDTH-1:0]    bit_sel;
  logic [WIDTH-1:0]    trial_cut;
  logic                one_hot;

  // Probe value and per-cycle decision helpers.
  always_comb begin
    mask      = WIDTH'(sign_mask(sig_q, WIDTH));
    probe     = trial_q ^ mask;
    bit_sel   = WIDTH'(1) << idx_q;
    trial_cut = ls_i ? (trial_q & ~bit_sel) : trial_q;
    // Odd parity excluding all-three-set means exactly one flag.
    one_hot   = (lg_i ^ eq_i ^ ls_i) & ~(lg_i & eq_i & ls_i);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    trial_d  = trial_q;
    result_d = result_q;
    idx_d    = idx_q;
    steps_d  = steps_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          sig_d   = sig_in_i;
          trial_d = WIDTH'(1) << (WIDTH - 1);
          idx_d   = STEP_W'(WIDTH - 1);
          steps_d = '0;
          err_d   = 1'b0;
          state_d = StProbe;
        end
      end
      StProbe: begin
        steps_d = steps_q + STEP_W'(1);
        if (!one_hot) begin
          err_d    = 1'b1;
          result_d = probe;
          state_d  = StDone;
        end else if (eq_i) begin
          result_d = probe;
          state_d  = StDone;
        end else if (idx_q == '0) begin
          trial_d  = trial_cut;
          result_d = trial_cut ^ mask;
          state_d  = StDone;
        end else begin
          trial_d  = trial_cut | (bit_sel >> 1);
          idx_d    = idx_q - STEP_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      sig_q    <= 1'b0;
      trial_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      steps_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      steps_q  <= steps_d;
      err_q    <= err_d;
    end
  end

  // Outputs are all decoded from registers.
  always_comb begin
    b_o      = probe;
    sig_o    = sig_q;
    busy_o   = (state_q == StProbe);
    done_o   = (state_q == StDone);
    result_o = result_q;
    steps_o  = steps_q;
    err_o    = err_q;
  end

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search with a behavioural comparator closing the loop.
module tb_sar_search;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned STEP_W = 3;

  typedef struct packed {
    logic [3:0] res;
    logic [2:0] steps;
    logic       err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              sig_in;
  logic [WIDTH-1:0]  b;
  logic              sig;
  logic              lg, eq, ls;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic [STEP_W-1:0] steps;
  logic              err;

  logic [3:0] a_val;
  logic       fault;
  logic       gt, lt;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  sar_search #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .sig_in_i (sig_in),
    .b_o      (b),
    .sig_o    (sig),
    .lg_i     (lg),
    .eq_i     (eq),
    .ls_i     (ls),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result),
    .steps_o  (steps),
    .err_o    (err)
  );

  // Comparator model; fault forces an illegal lg+eq pattern.
  always_comb begin
    if (sig) begin
      gt = $signed(a_val) > $signed(b);
      lt = $signed(a_val) < $signed(b);
    end else begin
      gt = a_val > b;
      lt = a_val < b;
    end
    lg = gt;
    ls = lt;
    eq = ~gt & ~lt;
    if (fault) begin
      lg = 1'b1;
      eq = 1'b1;
      ls = 1'b0;
    end
  end

  // Probes needed: a hit occurs once the trial reaches the offset-binary value,
  // which happens at the probe that sets its lowest 1 bit; zero never hits.
  function automatic logic [2:0] exp_steps(input logic [3:0] a, input logic s);
    logic [3:0] u;
    u = a ^ (s ? 4'h8 : 4'h0);
    for (int i = 0; i < 4; i++) begin
      if (u[i]) return 3'(4 - i);
    end
    return 3'd4;
  endfunction

  // Caller is just after a rising edge in IDLE; returns in probe cycle 1.
  task automatic launch(input logic [3:0] a, input logic s, input exp_t e, input bit push);
    a_val  = a;
    sig_in = s;
    start  = 1'b1;
    if (push) sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done, pops the scoreboard and checks the outcome and pulse width.
  task automatic finish_search(input int cnt0);
    int   cnt;
    bit   seen;
    exp_t e;
    cnt  = cnt0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      cnt++;
      if (done) seen = 1'b1;
    end
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: no done within 12 cycles, expected result=%0h", e.res);
      return;
    end
    n_checks++;
    if (result !== e.res) begin
      n_fail++;
      $display("FAIL result: got %0h expected %0h", result, e.res);
    end
    n_checks++;
    if (steps !== e.steps) begin
      n_fail++;
      $display("FAIL steps: got %0d expected %0d", steps, e.steps);
    end
    n_checks++;
    if (err !== e.err) begin
      n_fail++;
      $display("FAIL err: got %0b expected %0b", err, e.err);
    end
    n_checks++;
    if (cnt !== int'(e.steps) + 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL latency: done in cycle %0d busy=%0b expected cycle %0d busy=0",
               cnt, busy, int'(e.steps) + 1);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_width: done=%0b one cycle after pulse, expected 0", done);
    end
  endtask

  // Runs one search and checks each probe value; fault_at selects a forced-bad probe.
  task automatic search_probes(input logic [3:0] a, input logic s, input logic [15:0] probes,
                               input int n, input exp_t e, input int fault_at);
    launch(a, s, e, 1'b1);
    for (int k = 0; k < n; k++) begin
      if (k == fault_at) fault = 1'b1;
      @(negedge clk);
      n_checks++;
      if (b !== probes[15-4*k -: 4] || busy !== 1'b1 || sig !== s) begin
        n_fail++;
        $display("FAIL probe%0d: b=%0h busy=%0b sig=%0b expected b=%0h busy=1 sig=%0b",
                 k + 1, b, busy, sig, probes[15-4*k -: 4], s);
      end
      @(posedge clk); #1;
      fault = 1'b0;
    end
    finish_search(n);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start  = 1'b0;
    sig_in = 1'b0;
    a_val  = 4'h0;
    fault  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({b, sig, busy, done, result, steps, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: b=%0h sig=%0b busy=%0b done=%0b result=%0h steps=%0d err=%0b expected all 0",
               b, sig, busy, done, result, steps, err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_unsigned_zero();
    search_probes(4'h0, 1'b0, 16'h8421, 4, '{res: 4'h0, steps: 3'd4, err: 1'b0}, -1);
  endtask

  task automatic test_unsigned_early_eq();
    search_probes(4'h8, 1'b0, 16'h8000, 1, '{res: 4'h8, steps: 3'd1, err: 1'b0}, -1);
  endtask

  task automatic test_unsigned_max();
    search_probes(4'hF, 1'b0, 16'h8CEF, 4, '{res: 4'hF, steps: 3'd4, err: 1'b0}, -1);
  endtask

  task automatic test_signed_min();
    search_probes(4'h8, 1'b1, 16'h0CA9, 4, '{res: 4'h8, steps: 3'd4, err: 1'b0}, -1);
  endtask

  task automatic test_flag_fault();
    // a=5: probe 1 is 8 (ls), probe 2 is 4 and gets the illegal flags.
    search_probes(4'h5, 1'b0, 16'h8400, 2, '{res: 4'h4, steps: 3'd2, err: 1'b1}, 1);
  endtask

  task automatic test_start_ignored();
    launch(4'hF, 1'b0, '{res: 4'hF, steps: 3'd4, err: 1'b0}, 1'b1);
    start  = 1'b1;
    sig_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start  = 1'b0;
    sig_in = 1'b0;
    finish_search(2);
  endtask

  task automatic test_reset_mid_search();
    bit saw_done;
    launch(4'h0, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({b, busy, done, result, steps, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: b=%0h busy=%0b done=%0b result=%0h steps=%0d err=%0b expected all 0",
               b, busy, done, result, steps, err);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL reset_quiet: done/busy seen after reset, expected none");
    end
    @(posedge clk); #1;
  endtask

  // Every value in both modes, launched back-to-back right after each done.
  task automatic test_back_to_back_sweep();
    logic [3:0] a;
    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 16; v++) begin
        a = 4'(v);
        launch(a, s[0], '{res: a, steps: exp_steps(a, s[0]), err: 1'b0}, 1'b1);
        finish_search(0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_zero();
    test_unsigned_early_eq();
    test_unsigned_max();
    test_signed_min();
    test_flag_fault();
    test_start_ignored();
    test_reset_mid_search();
    test_back_to_back_sweep();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
